// File: rtl/cache_memory_lru.sv
// Set-associative L1 data array with true-LRU way management.
// Ports: req_* valid/ready request, rsp_* registered response.
module cache_memory_lru #(
  parameter int ADDR_SIZE   = 32,
  parameter int NUM_SETS    = 16,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [ADDR_SIZE-1:0]      req_addr,
  input  logic [31:0]               req_wdata,
  input  logic [3:0]                req_wstrb,
  input  logic [32*BLOCK_WORDS-1:0] req_fdata,
  output logic                      rsp_valid,
  output logic                      rsp_hit,
  output logic [$clog2(NUM_WAYS)-1:0] rsp_way,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_evict,
  output logic [ADDR_SIZE-1:0]      rsp_evict_addr,
  output logic [32*BLOCK_WORDS-1:0] rsp_evict_data
);

  localparam int OffSize  = $clog2(BLOCK_WORDS) + 2;
  localparam int SetSize  = $clog2(NUM_SETS);
  localparam int TagSize  = ADDR_SIZE - SetSize - OffSize;
  localparam int WaySize  = $clog2(NUM_WAYS);
  localparam int WordSize =
    (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int BlkBits  = 32 * BLOCK_WORDS;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_INV   = 2'b11;

  logic [BlkBits-1:0]  data_q [NUM_SETS][NUM_WAYS];
  logic [TagSize-1:0]  tag_q  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [WaySize-1:0]  age_q  [NUM_SETS][NUM_WAYS];

  logic               sweeping;
  logic [SetSize-1:0] sweep_set;

  logic [SetSize-1:0]  idx;
  logic [TagSize-1:0]  tag;
  logic [WordSize-1:0] word;
  logic                accept;
  logic                is_read;
  logic                is_write;
  logic                is_fill;
  logic                is_inv;

  assign idx  = req_addr[OffSize +: SetSize];
  assign tag  = req_addr[ADDR_SIZE-1 -: TagSize];
  assign word = WordSize'((req_addr >> 2)
              & ADDR_SIZE'(BLOCK_WORDS - 1));

  assign req_ready = !sweeping;
  assign accept    = req_valid && req_ready;
  assign is_read   = (req_op == OP_READ);
  assign is_write  = (req_op == OP_WRITE);
  assign is_fill   = (req_op == OP_FILL);
  assign is_inv    = (req_op == OP_INV);

  logic               hit;
  logic [WaySize-1:0] hit_way;
  logic               has_inv;
  logic [WaySize-1:0] inv_way;
  logic [WaySize-1:0] lru_way;

  // Descending scan so the lowest matching index is kept.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WaySize'(w);
      end
      if (!valid_q[idx][w]) begin
        has_inv = 1'b1;
        inv_way = WaySize'(w);
      end
      if (age_q[idx][w] == WaySize'(NUM_WAYS - 1))
        lru_way = WaySize'(w);
    end
  end

  logic [WaySize-1:0] fill_way;
  logic [WaySize-1:0] acc_way;
  logic [WaySize-1:0] touch_age;
  logic [BlkBits-1:0] line;
  logic [BlkBits-1:0] new_line;
  logic [31:0]        old_word;
  logic [31:0]        merged;
  logic               evict;
  logic               touch;
  logic [ADDR_SIZE-1:0] evict_addr;

  assign fill_way = hit     ? hit_way :
                    has_inv ? inv_way : lru_way;
  assign acc_way   = is_fill ? fill_way : hit_way;
  assign line      = data_q[idx][acc_way];
  assign old_word  = line[32*word +: 32];
  assign touch_age = age_q[idx][acc_way];

  always_comb begin
    merged = old_word;
    for (int b = 0; b < 4; b++)
      if (req_wstrb[b])
        merged[8*b +: 8] = req_wdata[8*b +: 8];
  end

  always_comb begin
    new_line = line;
    new_line[32*word +: 32] = merged;
  end

  assign evict = is_fill && !hit
              && valid_q[idx][fill_way]
              && dirty_q[idx][fill_way];
  assign evict_addr = {tag_q[idx][fill_way], idx,
                       {OffSize{1'b0}}};
  assign touch = accept
              && (((is_read || is_write) && hit) || is_fill);

  // Payload storage needs no reset; valid bits gate it.
  always_ff @(posedge clk) begin
    if (accept && is_fill) begin
      data_q[idx][fill_way] <= req_fdata;
      tag_q[idx][fill_way]  <= tag;
    end else if (accept && is_write && hit) begin
      data_q[idx][hit_way]  <= new_line;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= WaySize'(w);
      end
      sweeping       <= 1'b0;
      sweep_set      <= '0;
      rsp_valid      <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_way        <= '0;
      rsp_rdata      <= '0;
      rsp_evict      <= 1'b0;
      rsp_evict_addr <= '0;
      rsp_evict_data <= '0;
    end else begin
      rsp_valid      <= 1'b0;
      rsp_hit        <= 1'b0;
      rsp_way        <= '0;
      rsp_rdata      <= '0;
      rsp_evict      <= 1'b0;
      rsp_evict_addr <= '0;
      rsp_evict_data <= '0;
      if (sweeping) begin
        valid_q[sweep_set] <= '0;
        dirty_q[sweep_set] <= '0;
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[sweep_set][w] <= WaySize'(w);
        sweep_set <= sweep_set + 1'b1;
        if (sweep_set == SetSize'(NUM_SETS - 1))
          sweeping <= 1'b0;
        // Registered pulse lines up with the final clear.
        if (sweep_set == SetSize'(NUM_SETS - 2))
          rsp_valid <= 1'b1;
      end else if (accept && is_inv) begin
        sweeping  <= 1'b1;
        sweep_set <= '0;
      end else if (accept) begin
        rsp_valid <= 1'b1;
        if (touch) begin
          for (int w = 0; w < NUM_WAYS; w++) begin
            if (WaySize'(w) == acc_way)
              age_q[idx][w] <= '0;
            else if (age_q[idx][w] < touch_age)
              age_q[idx][w] <= age_q[idx][w] + 1'b1;
          end
        end
        if (is_read && hit) begin
          rsp_hit   <= 1'b1;
          rsp_way   <= hit_way;
          rsp_rdata <= old_word;
        end
        if (is_write && hit) begin
          dirty_q[idx][hit_way] <= 1'b1;
          rsp_hit   <= 1'b1;
          rsp_way   <= hit_way;
          rsp_rdata <= merged;
        end
        if (is_fill) begin
          valid_q[idx][fill_way] <= 1'b1;
          dirty_q[idx][fill_way] <= 1'b0;
          rsp_hit   <= hit;
          rsp_way   <= fill_way;
          rsp_evict <= evict;
          if (evict) begin
            rsp_evict_addr <= evict_addr;
            rsp_evict_data <= line;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_memory_lru.sv
// Scoreboard bench for cache_memory_lru against an
// LRU-list reference model.
module tb_cache_memory_lru;

  localparam int S  = 16;
  localparam int W  = 4;
  localparam int BW = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_wstrb;
  logic [127:0] req_fdata;
  logic         rsp_valid;
  logic         rsp_hit;
  logic [1:0]   rsp_way;
  logic [31:0]  rsp_rdata;
  logic         rsp_evict;
  logic [31:0]  rsp_evict_addr;
  logic [127:0] rsp_evict_data;

  always #5 clk = ~clk;

  cache_memory_lru #(
    .ADDR_SIZE(32), .NUM_SETS(S),
    .NUM_WAYS(W), .BLOCK_WORDS(BW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_fdata(req_fdata),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_way(rsp_way), .rsp_rdata(rsp_rdata),
    .rsp_evict(rsp_evict),
    .rsp_evict_addr(rsp_evict_addr),
    .rsp_evict_data(rsp_evict_data)
  );

  typedef struct {
    logic         hit;
    logic [1:0]   way;
    logic [31:0]  rdata;
    logic         evict;
    logic [31:0]  eaddr;
    logic [127:0] edata;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic        m_valid [S][W];
  logic        m_dirty [S][W];
  logic [23:0] m_tag   [S][W];
  logic [31:0] m_data  [S][W][BW];
  int          m_order [S][W];

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < S; s++)
      for (int w = 0; w < W; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_order[s][w] = w;
      end
  endtask

  // Recency list: position 0 is most recently used.
  task automatic touch(input int s, input int w);
    int p;
    p = 0;
    for (int i = 0; i < W; i++)
      if (m_order[s][i] == w) p = i;
    for (int i = p; i > 0; i--)
      m_order[s][i] = m_order[s][i-1];
    m_order[s][0] = w;
  endtask

  task automatic model_access(input logic [1:0] op,
                              input logic [31:0] addr,
                              input logic [31:0] wd,
                              input logic [3:0] st,
                              input logic [127:0] fd,
                              output exp_t e);
    int s, wi, hw, v;
    logic [23:0] t;
    logic [31:0] nw;
    s  = int'(addr[7:4]);
    t  = addr[31:8];
    wi = int'(addr[3:2]);
    e.hit = 0; e.way = 0; e.rdata = 0;
    e.evict = 0; e.eaddr = 0; e.edata = 0;
    hw = -1;
    for (int w = 0; w < W; w++)
      if (hw < 0 && m_valid[s][w] && m_tag[s][w] == t)
        hw = w;
    if (op == 2'b00 && hw >= 0) begin
      e.hit = 1; e.way = 2'(hw);
      e.rdata = m_data[s][hw][wi];
      touch(s, hw);
    end else if (op == 2'b01 && hw >= 0) begin
      nw = m_data[s][hw][wi];
      for (int b = 0; b < 4; b++)
        if (st[b]) nw[8*b +: 8] = wd[8*b +: 8];
      m_data[s][hw][wi] = nw;
      m_dirty[s][hw] = 1'b1;
      e.hit = 1; e.way = 2'(hw); e.rdata = nw;
      touch(s, hw);
    end else if (op == 2'b10) begin
      if (hw >= 0) begin
        v = hw; e.hit = 1;
      end else begin
        v = -1;
        for (int w = 0; w < W; w++)
          if (v < 0 && !m_valid[s][w]) v = w;
        if (v < 0) v = m_order[s][W-1];
        if (m_valid[s][v] && m_dirty[s][v]) begin
          e.evict = 1;
          e.eaddr = {m_tag[s][v], addr[7:4], 4'h0};
          for (int i = 0; i < BW; i++)
            e.edata[32*i +: 32] = m_data[s][v][i];
        end
      end
      e.way = 2'(v);
      for (int i = 0; i < BW; i++)
        m_data[s][v][i] = fd[32*i +: 32];
      m_valid[s][v] = 1'b1;
      m_dirty[s][v] = 1'b0;
      m_tag[s][v]   = t;
      touch(s, v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got valid want none");
      end else begin
        e = q.pop_front();
        chk("rsp_hit", rsp_hit, e.hit);
        chk("rsp_way", rsp_way, e.way);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_evict", rsp_evict, e.evict);
        chk("evict_addr", rsp_evict_addr, e.eaddr);
        chk("evict_data", rsp_evict_data, e.edata);
      end
    end
  end

  task automatic issue(input logic [1:0] op,
                       input logic [31:0] addr,
                       input logic [31:0] wd,
                       input logic [3:0] st,
                       input logic [127:0] fd);
    exp_t e;
    chk("req_ready", req_ready, 1'b1);
    model_access(op, addr, wd, st, fd, e);
    q.push_back(e);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    req_wdata = wd; req_wstrb = st; req_fdata = fd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic invalidate_all();
    exp_t e;
    chk("req_ready_inv", req_ready, 1'b1);
    e.hit = 0; e.way = 0; e.rdata = 0;
    e.evict = 0; e.eaddr = 0; e.edata = 0;
    q.push_back(e);
    model_reset();
    req_valid = 1'b1; req_op = 2'b11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < S; i++) begin
      chk("ready_low_sweep", req_ready, 1'b0);
      // Requests while not ready must be dropped.
      req_valid = (i < S - 1);
      req_op = 2'b00;
      req_addr = 32'h0000_1000;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("ready_after_sweep", req_ready, 1'b1);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [23:0] t;
    logic [3:0]  s;
    logic [1:0]  w;
    t = 24'(32'h40 + $urandom_range(0, 5));
    s = 4'($urandom_range(0, 3));
    w = 2'($urandom_range(0, 3));
    return {t, s, w, 2'b00};
  endfunction

  function automatic logic [127:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int r;
    logic [1:0] op;
    req_valid = 0; req_op = 0; req_addr = 0;
    req_wdata = 0; req_wstrb = 0; req_fdata = 0;
    model_reset();
    #12;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_hit", rsp_hit, 1'b0);
    chk("rst_evict", rsp_evict, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_eaddr", rsp_evict_addr, 32'h0);
    chk("rst_edata", rsp_evict_data, 128'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    issue(2'b00, 32'h0000_1000, 0, 0, 0);
    issue(2'b10, 32'h0000_1000, 0, 0,
          128'h00000044_00000033_00000022_00000011);
    issue(2'b00, 32'h0000_1008, 0, 0, 0);
    issue(2'b01, 32'h0000_1004, 32'hAABBCCDD, 4'b0101, 0);
    issue(2'b00, 32'h0000_1004, 0, 0, 0);

    invalidate_all();
    issue(2'b00, 32'h0000_1004, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      issue(2'b10, 32'h0000_2000 + 32'(i) * 32'h100,
            0, 0, rnd_blk());
    issue(2'b00, 32'h0000_2000, 0, 0, 0);
    issue(2'b10, 32'h0000_2400, 0, 0, rnd_blk());

    invalidate_all();
    for (int i = 0; i < 4; i++)
      issue(2'b10, 32'h0000_2000 + 32'(i) * 32'h100,
            0, 0, rnd_blk());
    issue(2'b01, 32'h0000_2104, 32'h1234_5678, 4'hF, 0);
    issue(2'b00, 32'h0000_2000, 0, 0, 0);
    issue(2'b00, 32'h0000_2200, 0, 0, 0);
    issue(2'b00, 32'h0000_2300, 0, 0, 0);
    issue(2'b10, 32'h0000_2500, 0, 0, rnd_blk());

    for (int i = 0; i < 300; i++) begin
      r  = int'($urandom_range(0, 99));
      op = (r < 35) ? 2'b00 : (r < 65) ? 2'b01 : 2'b10;
      issue(op, rnd_addr(), $urandom,
            4'($urandom_range(0, 15)), rnd_blk());
    end

    invalidate_all();
    for (int i = 0; i < 40; i++)
      issue(2'b10, rnd_addr(), 0, 0, rnd_blk());

    chk("req_ready_inv2", req_ready, 1'b1);
    model_reset();
    req_valid = 1'b1; req_op = 2'b11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    model_reset();
    #1;
    chk("midrst_ready", req_ready, 1'b1);
    chk("midrst_valid", rsp_valid, 1'b0);
    chk("midrst_hit", rsp_hit, 1'b0);
    chk("midrst_evict", rsp_evict, 1'b0);
    chk("midrst_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++)
      issue(2'b00, rnd_addr(), 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      r  = int'($urandom_range(0, 99));
      op = (r < 35) ? 2'b00 : (r < 65) ? 2'b01 : 2'b10;
      issue(op, rnd_addr(), $urandom,
            4'($urandom_range(0, 15)), rnd_blk());
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 128'(q.size()), 128'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
